// File: rtl/acq_sequencer_if.sv
// Control/status bundle between the host registers, the trigger decoder
// and the acquisition sequencer. The master side drives the requests,
// configuration and decoded trigger. The slave side is the sequencer.
interface acq_sequencer_if #(
  parameter int CNT_W  = 16,
  parameter int MISS_W = 8
);
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  record_len;
  logic [CNT_W-1:0]  holdoff_len;
  logic [CNT_W-1:0]  pulse_num;
  logic              trigger_start;
  logic              trigger_ready;
  logic              capture_en;
  logic              record_first;
  logic              record_last;
  logic [CNT_W-1:0]  pulse_cnt;
  logic [MISS_W-1:0] missed_cnt;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, record_len, holdoff_len, pulse_num, trigger_start,
    input  trigger_ready, capture_en, record_first, record_last,
           pulse_cnt, missed_cnt, busy, done
  );

  modport slave (
    input  start, abort, record_len, holdoff_len, pulse_num, trigger_start,
    output trigger_ready, capture_en, record_first, record_last,
           pulse_cnt, missed_cnt, busy, done
  );
endinterface

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arms the trigger decoder, opens one capture window
// per accepted trigger, waits the holdoff between windows and signals the
// end of a run after the programmed number of records. Every output comes
// straight from a flop. Strobes are computed from the next state so that
// they line up with the edge that enters that state.
module acq_sequencer #(
  parameter int CNT_W  = 16,
  parameter int MISS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  acq_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_HOLDOFF,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]  rec_len_reg, hold_len_reg, pulse_num_reg;
  logic [CNT_W-1:0]  win_cnt_reg, win_cnt_next;
  logic [CNT_W-1:0]  pulse_cnt_reg, pulse_cnt_next;
  logic [MISS_W-1:0] missed_cnt_reg, missed_cnt_next;
  logic [CNT_W-1:0]  eff_len;
  logic              latch_cfg;
  logic              first_next, last_next;

  logic trigger_ready_reg, capture_en_reg, record_first_reg, record_last_reg;
  logic busy_reg, done_reg;

  // A zero record length still produces a one-cycle window.
  assign eff_len = (rec_len_reg == '0) ? CNT_W'(1) : rec_len_reg;

  // Next-state, window/holdoff countdown and counter updates.
  always_comb begin
    state_next      = state_reg;
    win_cnt_next    = win_cnt_reg;
    pulse_cnt_next  = pulse_cnt_reg;
    missed_cnt_next = missed_cnt_reg;
    latch_cfg       = 1'b0;
    first_next      = 1'b0;
    last_next       = 1'b0;

    // Triggers that arrive while not armed are counted (saturating).
    if (bus.trigger_start && (state_reg == S_CAPTURE || state_reg == S_HOLDOFF ||
                              state_reg == S_DONE) && (missed_cnt_reg != '1))
      missed_cnt_next = missed_cnt_reg + MISS_W'(1);

    if (state_reg == S_IDLE) begin
      if (bus.start && !bus.abort && (bus.pulse_num != '0)) begin
        latch_cfg       = 1'b1;
        pulse_cnt_next  = '0;
        missed_cnt_next = '0;
        state_next      = S_ARMED;
      end
    end else if (bus.abort) begin
      // Abort beats trigger and window end; pulse_cnt keeps its value.
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_ARMED: begin
          if (bus.trigger_start) begin
            state_next   = S_CAPTURE;
            win_cnt_next = eff_len;
            first_next   = 1'b1;
            last_next    = (eff_len == CNT_W'(1));
          end
        end
        S_CAPTURE: begin
          if (win_cnt_reg <= CNT_W'(1)) begin
            pulse_cnt_next = pulse_cnt_reg + CNT_W'(1);
            if (pulse_cnt_next == pulse_num_reg) begin
              state_next = S_DONE;
            end else if (hold_len_reg == '0) begin
              state_next = S_ARMED;
            end else begin
              state_next   = S_HOLDOFF;
              win_cnt_next = hold_len_reg;
            end
          end else begin
            win_cnt_next = win_cnt_reg - CNT_W'(1);
            last_next    = (win_cnt_reg == CNT_W'(2));
          end
        end
        S_HOLDOFF: begin
          if (win_cnt_reg <= CNT_W'(1))
            state_next = S_ARMED;
          else
            win_cnt_next = win_cnt_reg - CNT_W'(1);
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      rec_len_reg       <= '0;
      hold_len_reg      <= '0;
      pulse_num_reg     <= '0;
      win_cnt_reg       <= '0;
      pulse_cnt_reg     <= '0;
      missed_cnt_reg    <= '0;
      trigger_ready_reg <= 1'b0;
      capture_en_reg    <= 1'b0;
      record_first_reg  <= 1'b0;
      record_last_reg   <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      state_reg      <= state_next;
      win_cnt_reg    <= win_cnt_next;
      pulse_cnt_reg  <= pulse_cnt_next;
      missed_cnt_reg <= missed_cnt_next;
      if (latch_cfg) begin
        rec_len_reg   <= bus.record_len;
        hold_len_reg  <= bus.holdoff_len;
        pulse_num_reg <= bus.pulse_num;
      end
      trigger_ready_reg <= (state_next == S_ARMED);
      capture_en_reg    <= (state_next == S_CAPTURE);
      record_first_reg  <= first_next;
      record_last_reg   <= last_next;
      busy_reg          <= (state_next != S_IDLE);
      done_reg          <= (state_next == S_DONE);
    end
  end

  assign bus.trigger_ready = trigger_ready_reg;
  assign bus.capture_en    = capture_en_reg;
  assign bus.record_first  = record_first_reg;
  assign bus.record_last   = record_last_reg;
  assign bus.pulse_cnt     = pulse_cnt_reg;
  assign bus.missed_cnt    = missed_cnt_reg;
  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer. The reference model tracks each run by
// timestamps (trigger cycle, holdoff release cycle, done cycle) and derives
// the expected outputs for every cycle from them.
module tb_acq_sequencer;
  localparam int CNT_W    = 16;
  localparam int MISS_W   = 8;
  localparam int MISS_MAX = (1 << MISS_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  acq_sequencer_if #(.CNT_W(CNT_W), .MISS_W(MISS_W)) bus ();
  acq_sequencer #(.CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: run timeline expressed as cycle numbers.
  int m_active, m_ready_at, m_trig_at, m_done_at;
  int m_L, m_H, m_N, m_pcnt, m_miss;

  logic [CNT_W-1:0] rl_v, hl_v, pn_v;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit m_armed(input int k);
    return (m_active != 0) && (m_trig_at < 0) && (m_done_at < 0) && (k >= m_ready_at);
  endfunction

  function automatic bit m_inwin(input int k);
    return (m_active != 0) && (m_trig_at >= 0) && (k >= m_trig_at) && (k <= m_trig_at + m_L - 1);
  endfunction

  task automatic model_reset();
    m_active = 0; m_ready_at = 0; m_trig_at = -1; m_done_at = -1;
    m_L = 1; m_H = 0; m_N = 0; m_pcnt = 0; m_miss = 0;
  endtask

  // Advance the model over one rising edge with the inputs sampled there.
  task automatic model_edge(input bit st, input bit ab, input bit tr,
                            input int rl, input int hl, input int pn);
    int k, c;
    bit armed, inwin;
    k = cyc;
    cyc++;
    c = cyc;
    if (m_active == 0) begin
      if (st && !ab && pn != 0) begin
        m_active = 1; m_L = (rl == 0) ? 1 : rl; m_H = hl; m_N = pn;
        m_pcnt = 0; m_miss = 0; m_ready_at = c; m_trig_at = -1; m_done_at = -1;
      end
    end else begin
      armed = m_armed(k);
      inwin = m_inwin(k);
      if (tr && !armed && m_miss < MISS_MAX) m_miss++;
      if (ab) begin
        m_active = 0; m_trig_at = -1;
      end else if (armed && tr) begin
        m_trig_at = c;
      end else if (inwin && k == m_trig_at + m_L - 1) begin
        m_pcnt++;
        m_trig_at = -1;
        if (m_pcnt == m_N) m_done_at = c;
        else m_ready_at = c + m_H;
      end else if (m_done_at == k) begin
        m_active = 0;
      end
    end
  endtask

  task automatic compare_all();
    bit cap;
    cap = m_inwin(cyc);
    check("trigger_ready", bus.trigger_ready, m_armed(cyc));
    check("capture_en",    bus.capture_en,    cap);
    check("record_first",  bus.record_first,  cap && (cyc == m_trig_at));
    check("record_last",   bus.record_last,   cap && (cyc == m_trig_at + m_L - 1));
    check("busy",          bus.busy,          m_active != 0);
    check("done",          bus.done,          (m_active != 0) && (m_done_at == cyc));
    check("pulse_cnt",     bus.pulse_cnt,     m_pcnt);
    check("missed_cnt",    bus.missed_cnt,    m_miss);
  endtask

  task automatic step(input bit st, input bit ab, input bit tr, input bit scramble);
    if (scramble) begin
      rl_v = CNT_W'($urandom);
      hl_v = CNT_W'($urandom);
      pn_v = CNT_W'($urandom);
    end
    bus.start = st; bus.abort = ab; bus.trigger_start = tr;
    bus.record_len = rl_v; bus.holdoff_len = hl_v; bus.pulse_num = pn_v;
    @(posedge clk);
    model_edge(st, ab, tr, int'(rl_v), int'(hl_v), int'(pn_v));
    #1;
    compare_all();
    bus.start = 1'b0; bus.abort = 1'b0; bus.trigger_start = 1'b0;
  endtask

  task automatic do_start(input int rl, input int hl, input int pn);
    rl_v = CNT_W'(rl); hl_v = CNT_W'(hl); pn_v = CNT_W'(pn);
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // tmode: 0 = trigger whenever armed, 1 = trigger held high, 2 = random.
  task automatic run(input int tmode, input int st_pct, input int ab_pct, input int budget);
    int n;
    bit tr, st, ab;
    n = 0;
    while (m_active != 0 && n < budget) begin
      case (tmode)
        0:       tr = bus.trigger_ready;
        1:       tr = 1'b1;
        default: tr = 1'($urandom_range(0, 1));
      endcase
      st = ($urandom_range(0, 99) < st_pct);
      ab = ($urandom_range(0, 99) < ab_pct);
      step(st, ab, tr, !st);
      n++;
    end
    if (m_active != 0) check("run_timeout", 1, 0);
  endtask

  initial begin
    int rl, hl, pn, guard;
    bus.start = 0; bus.abort = 0; bus.trigger_start = 0;
    bus.record_len = '0; bus.holdoff_len = '0; bus.pulse_num = '0;
    rl_v = '0; hl_v = '0; pn_v = '0;
    model_reset();

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
    $display("reset: outputs checked");

    // Basic run: 4-cycle windows, holdoff 2, three records.
    do_start(4, 2, 3);
    run(0, 0, 0, 200);
    check("basic_pulse_cnt", bus.pulse_cnt, 3);
    check("basic_missed", bus.missed_cnt, 0);
    $display("basic run: L=4 H=2 N=3 pulse_cnt=%0d missed=%0d", bus.pulse_cnt, bus.missed_cnt);

    // Zero lengths, with a start request issued mid-run.
    do_start(0, 0, 2);
    run(0, 30, 0, 200);
    check("zero_pulse_cnt", bus.pulse_cnt, 2);
    $display("zero run: L=0 H=0 N=2 pulse_cnt=%0d", bus.pulse_cnt);

    // pulse_num = 0 is ignored; start+abort together is ignored.
    do_start(3, 1, 0);
    check("pn0_busy", bus.busy, 0);
    rl_v = 3; hl_v = 1; pn_v = 2;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("start_abort_busy", bus.busy, 0);
    $display("ignored starts: busy=%0d", bus.busy);

    // Trigger held high: 10 window + 5 holdoff + 10 window + 1 done cycle.
    do_start(10, 5, 2);
    run(1, 0, 0, 200);
    check("missed_10_5", bus.missed_cnt, 26);
    $display("missed run: L=10 H=5 N=2 missed=%0d", bus.missed_cnt);

    // Saturation: 300-cycle window with trigger held high.
    do_start(300, 0, 1);
    run(1, 0, 0, 400);
    check("missed_sat", bus.missed_cnt, MISS_MAX);
    $display("saturation run: L=300 missed=%0d", bus.missed_cnt);

    // Abort mid-window of record 2 of 4.
    do_start(5, 1, 4);
    guard = 0;
    while (!(m_pcnt == 1 && m_inwin(cyc) && cyc > m_trig_at) && guard < 100) begin
      step(1'b0, 1'b0, bus.trigger_ready, 1'b1);
      guard++;
    end
    check("abort_reached", guard < 100, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("abort_capture_en", bus.capture_en, 0);
    check("abort_pulse_cnt", bus.pulse_cnt, 1);
    check("abort_done", bus.done, 0);
    do_start(2, 0, 1);
    check("restart_pulse_cnt", bus.pulse_cnt, 0);
    run(0, 0, 0, 50);
    $display("abort run: pulse_cnt after restart=%0d", bus.pulse_cnt);

    // Randomized runs with random triggers, stray starts and rare aborts.
    for (int r = 0; r < 25; r++) begin
      rl = $urandom_range(0, 6); hl = $urandom_range(0, 4); pn = $urandom_range(1, 4);
      do_start(rl, hl, pn);
      run(2, 10, 2, 500);
      $display("random run %0d: L=%0d H=%0d N=%0d pulse_cnt=%0d missed=%0d",
               r, rl, hl, pn, bus.pulse_cnt, bus.missed_cnt);
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Asynchronous reset in the middle of a window.
    do_start(8, 1, 2);
    guard = 0;
    while (!(m_inwin(cyc) && cyc > m_trig_at) && guard < 50) begin
      step(1'b0, 1'b0, bus.trigger_ready, 1'b0);
      guard++;
    end
    check("arst_reached", bus.capture_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_capture_en", bus.capture_en, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_trigger_ready", bus.trigger_ready, 0);
    check("arst_record_first", bus.record_first, 0);
    check("arst_record_last", bus.record_last, 0);
    check("arst_done", bus.done, 0);
    check("arst_pulse_cnt", bus.pulse_cnt, 0);
    check("arst_missed_cnt", bus.missed_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    $display("async reset: busy=%0d capture_en=%0d", bus.busy, bus.capture_en);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/acq_sequencer.md
# acq_sequencer

Acquisition sequencer for the ADQ214 lidar capture path. It arms the trigger decoder, accepts its `trigger_start`, and opens a capture window of a programmed length for each laser pulse. After each window it waits a programmed holdoff. It repeats this for a programmed number of pulses (one accumulation run), then signals completion. It sits between the host-facing control registers and the trigger decoder / sample accumulator.

## Interface
- `CNT_W`, default 16: width of the record length, holdoff and count fields.
- `MISS_W`, default 8: width of the missed-trigger counter.

Ports (name, direction, width, meaning):
- `clk`  in  1  sample clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle request to begin a run.
- `abort`  in  1  single-cycle request to terminate a run.
- `record_len`  in  CNT_W  capture window length in clocks; latched on `start`.
- `holdoff_len`  in  CNT_W  idle clocks between windows; latched on `start`.
- `pulse_num`  in  CNT_W  records per run; latched on `start`.
- `trigger_start`  in  1  decoded trigger from the trigger decoder.
- `trigger_ready`  out  1  arms the trigger decoder.
- `capture_en`  out  1  high during a capture window.
- `record_first`  out  1  high on the first window cycle.
- `record_last`  out  1  high on the last window cycle.
- `pulse_cnt`  out  CNT_W  records completed in the current or last run.
- `missed_cnt`  out  MISS_W  triggers seen while not ARMED; saturating.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle pulse marking normal run completion.

## Operation
- States: IDLE, ARMED, CAPTURE, HOLDOFF, DONE. All outputs are registered.
- Reset (asynchronous): state IDLE; every output 0; `pulse_cnt` = 0; `missed_cnt` = 0; latched configuration = 0.

IDLE
- `start`=1, `abort`=0, `pulse_num`≠0:
  - Latch `record_len`, `holdoff_len`, `pulse_num`.
  - Clear `pulse_cnt` and `missed_cnt`.
  - Go to ARMED.
- `start` with `pulse_num`=0 is ignored.
- `abort` has priority over `start` when both are high.

ARMED
- `trigger_ready`=1.
- `trigger_start`=1: go to CAPTURE; load the window counter with the latched record length. A latched `record_len` of 0 is treated as 1.

CAPTURE
- `capture_en`=1 for exactly L cycles, where L is the effective record length.
- `record_first` on cycle 1; `record_last` on cycle L. Both are high together when L=1.
- On leaving CAPTURE, `pulse_cnt` increments.
  - If the new count equals `pulse_num`: go to DONE.
  - Otherwise, if holdoff=0: go to ARMED.
  - Otherwise: go to HOLDOFF.

HOLDOFF
- Stay exactly `holdoff_len` cycles, then go to ARMED.

DONE
- `done`=1 for one cycle, then IDLE.

Rules in all states
- `trigger_start`=1 in CAPTURE, HOLDOFF or DONE increments `missed_cnt`. The counter saturates at all-ones and never wraps.
- `trigger_start` in IDLE is ignored and not counted.
- `abort` in any state other than IDLE: next state IDLE; all strobes drop at that edge; no `done`; `pulse_cnt` holds its value.
- `abort` wins over a simultaneous trigger or window end.
- `start` while `busy` is ignored.
- Changes to `record_len`, `holdoff_len` or `pulse_num` during a run have no effect.
- `pulse_cnt` holds after DONE until the next accepted `start`.

## Timing
- `start` sampled at edge N: at edge N
  - `busy`=1 and `trigger_ready`=1.
- `trigger_start` sampled at edge T in ARMED: at edge T
  - `trigger_ready`=0.
  - `capture_en`=1 and `record_first`=1.
- The window spans edges T to T+L-1. At edge T+L:
  - `capture_en`=0.
  - `pulse_cnt` has incremented.
- Holdoff H>0: `trigger_ready` returns at edge T+L+H.
- Holdoff H=0: `trigger_ready` returns at edge T+L.
- Last record: at edge T+L
  - `done`=1.
  - `busy` stays 1 through the DONE cycle.
- At edge T+L+1: `done`=0 and `busy`=0.
- The trigger decoder registers its output only while `trigger_ready`=1. A trigger arriving in the cycle after `trigger_ready` falls is therefore counted as missed, not captured.

## Test plan
- Basic run: `record_len`=4, `holdoff_len`=2, `pulse_num`=3, trigger on every ARMED cycle → three 4-cycle `capture_en` windows separated by 2+1 gap cycles; `pulse_cnt` steps 1,2,3; one `done`; `missed_cnt`=0.
- Zero edge cases: `record_len`=0, `holdoff_len`=0, `pulse_num`=2 → 1-cycle windows with `record_first` and `record_last` high together; ARMED directly after CAPTURE. Separately, `pulse_num`=0 with `start` → `busy` stays 0.
- Missed triggers: `trigger_start` held high through a 10-cycle window and 5-cycle holdoff → `missed_cnt` increments each of those cycles. Driving 300 such cycles with `MISS_W`=8 → saturates at 255.
- Abort mid-CAPTURE of record 2 of 4 → next edge: IDLE, `capture_en`=0, `pulse_cnt`=1, no `done`. A following `start` clears `pulse_cnt` to 0.
- Priority: `start` and `abort` together in IDLE → stays IDLE. `start` during a run → ignored. Reconfiguring inputs mid-run → window lengths unchanged.
- Reset asserted mid-CAPTURE, asynchronously between clock edges → all outputs 0 immediately; IDLE after release.
